// File: rtl/rr_encoder4_2.sv
// rr_encoder4_2
// Round-robin request encoder. Four request lines compete for a single
// register-file write port. The winning index is offered on reg_no with a
// valid/out_ready handshake. After acceptance, a one-cycle one-hot grant goes
// back to the winner.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req[3:0]   request lines; requester i holds bit i until it sees grant[i]
//   out_ready  downstream accepts reg_no while valid is high
//   valid      reg_no holds a selected request index
//   reg_no     encoded index of the selected requester
//   grant      one-hot acknowledge, high for exactly one cycle
//   busy       high whenever the encoder is not idle
//
// Each grant takes three cycles: IDLE (scan), OFFER (handshake) and ACK (grant).

module rr_encoder4_2 #(
    parameter logic [1:0] RESET_PTR = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic       valid,
    output logic [1:0] reg_no,
    output logic [3:0] grant,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] last_ptr;
    logic [1:0] winner;

    // Find the first set request, scanning upward from last_ptr+1 and
    // wrapping 3->0. The last probe lands on last_ptr itself, so a lone
    // requester wins again. The 2-bit index arithmetic wraps naturally.
    function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = last + 2'd1;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    always_comb begin
        winner = rr_pick(req, last_ptr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            valid    <= 1'b0;
            reg_no   <= 2'b00;
            grant    <= 4'b0000;
            busy     <= 1'b0;
            last_ptr <= RESET_PTR;
        end else begin
            case (state)
                IDLE: begin
                    grant <= 4'b0000;
                    if (req != 4'b0000) begin
                        state  <= OFFER;
                        valid  <= 1'b1;
                        reg_no <= winner;
                        busy   <= 1'b1;
                    end else begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                OFFER: begin
                    // reg_no stays frozen and req is ignored until acceptance.
                    // A winner that drops its request is still offered.
                    if (out_ready) begin
                        state    <= ACK;
                        valid    <= 1'b0;
                        grant    <= onehot(reg_no);
                        last_ptr <= reg_no;
                    end
                end
                ACK: begin
                    // req is not looked at here. This gives the granted
                    // requester one cycle to drop its bit before the next scan.
                    state <= IDLE;
                    grant <= 4'b0000;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    grant <= 4'b0000;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_encoder4_2.sv
module tb_rr_encoder4_2;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       out_ready;
    logic       valid;
    logic [1:0] reg_no;
    logic [3:0] grant;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    rr_encoder4_2 #(.RESET_PTR(2'd3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .out_ready (out_ready),
        .valid     (valid),
        .reg_no    (reg_no),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       out_ready;
        logic       valid;
        logic [1:0] reg_no;
        logic [3:0] grant;
        logic       busy;
    } vec_t;

    localparam int NV = 43;
    vec_t tbl [NV];

    function automatic vec_t mk(logic r, logic [3:0] q, logic o,
                                logic v, logic [1:0] n, logic [3:0] g, logic b);
        vec_t t;
        t.rst_n = r; t.req = q; t.out_ready = o;
        t.valid = v; t.reg_no = n; t.grant = g; t.busy = b;
        return t;
    endfunction

    task automatic check(input string name, input logic v, input logic [1:0] n,
                         input logic [3:0] g, input logic b);
        logic [7:0] got, exp;
        got = {valid, reg_no, grant, busy};
        exp = {v, n, g, b};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got valid=%b reg_no=%b grant=%b busy=%b, want valid=%b reg_no=%b grant=%b busy=%b",
                     name, valid, reg_no, grant, busy, v, n, g, b);
        end
        // Invariants: grant all-zero or one-hot; never together with valid.
        n_cmp++;
        if (!$onehot0(grant) || (valid && grant != 4'b0000)) begin
            n_bad++;
            $display("FAIL %s_invariant: got valid=%b grant=%b, want grant onehot0 and not with valid",
                     name, valid, grant);
        end
    endtask

    initial begin
        // Lone requester 2: offer, grant, then idle once it drops its bit.
        tbl[0]  = mk(1, 4'b0100, 1, 1, 2'd2, 4'b0000, 1);
        tbl[1]  = mk(1, 4'b0100, 1, 0, 2'd2, 4'b0100, 1);
        tbl[2]  = mk(1, 4'b0000, 1, 0, 2'd2, 4'b0000, 0);
        tbl[3]  = mk(1, 4'b0000, 1, 0, 2'd2, 4'b0000, 0);
        // Synchronous-looking reset row, then all four requesting: 0,1,2,3,0.
        tbl[4]  = mk(0, 4'b0000, 0, 0, 2'd0, 4'b0000, 0);
        tbl[5]  = mk(1, 4'b1111, 1, 1, 2'd0, 4'b0000, 1);
        tbl[6]  = mk(1, 4'b1111, 1, 0, 2'd0, 4'b0001, 1);
        tbl[7]  = mk(1, 4'b1111, 1, 0, 2'd0, 4'b0000, 0);
        tbl[8]  = mk(1, 4'b1111, 1, 1, 2'd1, 4'b0000, 1);
        tbl[9]  = mk(1, 4'b1111, 1, 0, 2'd1, 4'b0010, 1);
        tbl[10] = mk(1, 4'b1111, 1, 0, 2'd1, 4'b0000, 0);
        tbl[11] = mk(1, 4'b1111, 1, 1, 2'd2, 4'b0000, 1);
        tbl[12] = mk(1, 4'b1111, 1, 0, 2'd2, 4'b0100, 1);
        tbl[13] = mk(1, 4'b1111, 1, 0, 2'd2, 4'b0000, 0);
        tbl[14] = mk(1, 4'b1111, 1, 1, 2'd3, 4'b0000, 1);
        tbl[15] = mk(1, 4'b1111, 1, 0, 2'd3, 4'b1000, 1);
        tbl[16] = mk(1, 4'b1111, 1, 0, 2'd3, 4'b0000, 0);
        tbl[17] = mk(1, 4'b1111, 1, 1, 2'd0, 4'b0000, 1);
        tbl[18] = mk(1, 4'b1111, 1, 0, 2'd0, 4'b0001, 1);
        tbl[19] = mk(1, 4'b0000, 1, 0, 2'd0, 4'b0000, 0);
        // Back-pressure: five cycles of stable offer, then grant.
        tbl[20] = mk(1, 4'b0010, 0, 1, 2'd1, 4'b0000, 1);
        tbl[21] = mk(1, 4'b0010, 0, 1, 2'd1, 4'b0000, 1);
        tbl[22] = mk(1, 4'b0010, 0, 1, 2'd1, 4'b0000, 1);
        tbl[23] = mk(1, 4'b0010, 0, 1, 2'd1, 4'b0000, 1);
        tbl[24] = mk(1, 4'b0010, 0, 1, 2'd1, 4'b0000, 1);
        tbl[25] = mk(1, 4'b0010, 1, 0, 2'd1, 4'b0010, 1);
        tbl[26] = mk(1, 4'b0000, 1, 0, 2'd1, 4'b0000, 0);
        // Grant 2, then 0101 must pick 0 (wrap), then 2.
        tbl[27] = mk(1, 4'b0100, 1, 1, 2'd2, 4'b0000, 1);
        tbl[28] = mk(1, 4'b0100, 1, 0, 2'd2, 4'b0100, 1);
        tbl[29] = mk(1, 4'b0101, 1, 0, 2'd2, 4'b0000, 0);
        tbl[30] = mk(1, 4'b0101, 1, 1, 2'd0, 4'b0000, 1);
        tbl[31] = mk(1, 4'b0101, 1, 0, 2'd0, 4'b0001, 1);
        tbl[32] = mk(1, 4'b0100, 1, 0, 2'd0, 4'b0000, 0);
        tbl[33] = mk(1, 4'b0100, 1, 1, 2'd2, 4'b0000, 1);
        tbl[34] = mk(1, 4'b0100, 1, 0, 2'd2, 4'b0100, 1);
        tbl[35] = mk(1, 4'b0000, 1, 0, 2'd2, 4'b0000, 0);
        // Winner 3 drops its request mid-offer: still granted, last_ptr=3.
        tbl[36] = mk(1, 4'b1000, 0, 1, 2'd3, 4'b0000, 1);
        tbl[37] = mk(1, 4'b0000, 0, 1, 2'd3, 4'b0000, 1);
        tbl[38] = mk(1, 4'b0000, 1, 0, 2'd3, 4'b1000, 1);
        tbl[39] = mk(1, 4'b0000, 1, 0, 2'd3, 4'b0000, 0);
        // last_ptr=3: 1001 scans 0 first, so 0 wins.
        tbl[40] = mk(1, 4'b1001, 0, 1, 2'd0, 4'b0000, 1);
        tbl[41] = mk(1, 4'b1001, 1, 0, 2'd0, 4'b0001, 1);
        tbl[42] = mk(1, 4'b0000, 1, 0, 2'd0, 4'b0000, 0);

        rst_n = 1'b0;
        req = 4'b0000;
        out_ready = 1'b0;
        #1;
        check("reset_async", 0, 2'd0, 4'b0000, 0);
        @(posedge clk);
        #1;
        check("reset_held", 0, 2'd0, 4'b0000, 0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst_n     = tbl[i].rst_n;
            req       = tbl[i].req;
            out_ready = tbl[i].out_ready;
            @(posedge clk);
            #1;
            check($sformatf("row%0d", i), tbl[i].valid, tbl[i].reg_no,
                  tbl[i].grant, tbl[i].busy);
        end

        // Asynchronous reset in the middle of an offer of index 3.
        @(negedge clk);
        req = 4'b1000;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre_reset_offer", 1, 2'd3, 4'b0000, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_mid_offer", 0, 2'd0, 4'b0000, 0);
        @(posedge clk);
        #1;
        check("reset_mid_offer_edge", 0, 2'd0, 4'b0000, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_offer", 1, 2'd3, 4'b0000, 1);
        @(posedge clk);
        #1;
        check("post_reset_grant", 0, 2'd3, 4'b1000, 1);
        @(negedge clk);
        req = 4'b0000;
        @(posedge clk);
        #1;
        check("post_reset_idle", 0, 2'd3, 4'b0000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
